// File: rtl/gig_mac_tx_sched_if.sv
// AXI4 master/slave bundle between the TX descriptor scheduler and the MAC CSR window.
// Single-beat only: burst fields are carried for protocol completeness.
interface gig_mac_tx_sched_if #(
    parameter int unsigned AXI_WIDTH_AD = 32,
    parameter int unsigned AXI_WIDTH_DA = 32
);
    logic [AXI_WIDTH_AD-1:0]   AWADDR;
    logic [7:0]                AWLEN;
    logic [2:0]                AWSIZE;
    logic [1:0]                AWBURST;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [AXI_WIDTH_DA-1:0]   WDATA;
    logic [AXI_WIDTH_DA/8-1:0] WSTRB;
    logic                      WLAST;
    logic                      WVALID;
    logic                      WREADY;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    logic [AXI_WIDTH_AD-1:0]   ARADDR;
    logic [7:0]                ARLEN;
    logic [2:0]                ARSIZE;
    logic [1:0]                ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [AXI_WIDTH_DA-1:0]   RDATA;
    logic [1:0]                RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RDATA, RRESP, RLAST, RVALID, input RREADY
    );
endinterface

// File: rtl/gig_mac_tx_sched.sv
// Queues TX requests and pushes them into the MAC descriptor queue over a
// single-outstanding AXI4 master, caching the free-room count between status reads.
module gig_mac_tx_sched #(
    parameter int unsigned AXI_WIDTH_AD  = 32,
    parameter int unsigned AXI_WIDTH_DA  = 32,
    parameter logic [31:0] CSR_BASE      = 32'h3000_0000,
    parameter logic [31:0] OFF_DESC_STAT = 32'h20,
    parameter logic [31:0] OFF_DESC_ADDR = 32'h24,
    parameter logic [31:0] OFF_DESC_LEN  = 32'h28,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned POLL_GAP      = 16
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [15:0] req_len,
    gig_mac_tx_sched_if.master axi,
    output logic        busy,
    output logic        err,
    output logic [15:0] sent_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [AXI_WIDTH_AD-1:0] STAT_ADDR = AXI_WIDTH_AD'(CSR_BASE + OFF_DESC_STAT);
    localparam logic [AXI_WIDTH_AD-1:0] DADR_ADDR = AXI_WIDTH_AD'(CSR_BASE + OFF_DESC_ADDR);
    localparam logic [AXI_WIDTH_AD-1:0] DLEN_ADDR = AXI_WIDTH_AD'(CSR_BASE + OFF_DESC_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_AR, S_RD_R, S_GAP, S_WA, S_BA, S_WL, S_BL
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      fifo_addr [FIFO_DEPTH];
    logic [15:0]      fifo_len  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty;
    logic             push, pop;
    logic [31:0]      head_addr;
    logic [15:0]      head_len;

    logic [15:0]      rooms;
    logic [GAP_W-1:0] gap_cnt;
    logic             aw_done, w_done;
    logic             aw_ok, w_ok, in_write;
    logic             err_set, commit, rooms_load;
    logic             unused_rd;

    assign unused_rd = ^{axi.RDATA[AXI_WIDTH_DA-1:16], axi.RLAST};

    // Request FIFO; a full FIFO refuses a push even when a pop happens the same cycle.
    assign fifo_empty = (fifo_cnt == '0);
    assign req_ready  = (fifo_cnt != CNT_W'(FIFO_DEPTH));
    assign push       = req_valid && req_ready;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_len   = fifo_len[rd_ptr];

    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= req_addr;
            fifo_len[wr_ptr]  <= req_len;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (!push && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    assign in_write = (state == S_WA) || (state == S_WL);
    assign aw_ok    = aw_done || (axi.AWVALID && axi.AWREADY);
    assign w_ok     = w_done  || (axi.WVALID  && axi.WREADY);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty && head_len != '0)
                    state_nxt = (rooms != '0) ? S_WA : S_RD_AR;
            end
            S_RD_AR: if (axi.ARREADY) state_nxt = S_RD_R;
            S_RD_R: begin
                if (axi.RVALID) begin
                    if (axi.RRESP != 2'b00)          state_nxt = S_IDLE;
                    else if (axi.RDATA[15:0] == '0)  state_nxt = S_GAP;
                    else                             state_nxt = S_WA;
                end
            end
            S_GAP:   if (gap_cnt == GAP_W'(POLL_GAP - 1)) state_nxt = S_RD_AR;
            S_WA:    if (aw_ok && w_ok) state_nxt = S_BA;
            S_BA: begin
                if (axi.BVALID) state_nxt = (axi.BRESP != 2'b00) ? S_IDLE : S_WL;
            end
            S_WL:    if (aw_ok && w_ok) state_nxt = S_BL;
            S_BL:    if (axi.BVALID) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        axi.AWLEN   = '0;
        axi.AWSIZE  = 3'd2;
        axi.AWBURST = 2'b01;
        axi.ARLEN   = '0;
        axi.ARSIZE  = 3'd2;
        axi.ARBURST = 2'b01;
        axi.WSTRB   = '1;
        axi.WLAST   = 1'b1;
        axi.ARVALID = (state == S_RD_AR);
        axi.ARADDR  = (state == S_RD_AR) ? STAT_ADDR : '0;
        axi.RREADY  = (state == S_RD_R);
        axi.AWVALID = in_write && !aw_done;
        axi.WVALID  = in_write && !w_done;
        axi.BREADY  = (state == S_BA) || (state == S_BL);
        axi.AWADDR  = '0;
        axi.WDATA   = '0;
        if (state == S_WA) begin
            axi.AWADDR = DADR_ADDR;
            axi.WDATA  = AXI_WIDTH_DA'(head_addr);
        end else if (state == S_WL) begin
            axi.AWADDR = DLEN_ADDR;
            axi.WDATA  = AXI_WIDTH_DA'({16'h0, head_len});
        end
        rooms_load = (state == S_RD_R) && axi.RVALID && (axi.RRESP == 2'b00);
        commit     = (state == S_BL) && axi.BVALID && (axi.BRESP == 2'b00);
        err_set    = ((state == S_IDLE) && !fifo_empty && (head_len == '0))
                  || ((state == S_RD_R) && axi.RVALID && (axi.RRESP != 2'b00))
                  || ((state == S_BA || state == S_BL) && axi.BVALID && (axi.BRESP != 2'b00));
        pop        = err_set || commit;
        busy       = !fifo_empty || (state != S_IDLE);
    end

    // Handshake-done flags let AWVALID and WVALID drop independently within WA/WL.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            gap_cnt  <= '0;
            rooms    <= '0;
            sent_cnt <= '0;
            err      <= 1'b0;
        end else begin
            aw_done <= in_write && !(aw_ok && w_ok) && aw_ok;
            w_done  <= in_write && !(aw_ok && w_ok) && w_ok;
            gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (err_set) err <= 1'b1;
            if (rooms_load)  rooms <= axi.RDATA[15:0];
            else if (commit) rooms <= (rooms == '0) ? '0 : rooms - 16'd1;
            if (commit) sent_cnt <= sent_cnt + 16'd1;
        end
    end

endmodule
